// File: rtl/uc_pkg.sv
// Shared types and constants for the multicycle control unit (uc_multiciclo).
// Optional instruction counter is enabled by defining UC_CONTADOR_EN.
package uc_pkg;

  localparam int unsigned OPC_W    = 6;
  localparam int unsigned OP_W     = 3;
  localparam int unsigned CLS_W    = 2;
  localparam int unsigned SUB_W    = 4;
  localparam int unsigned NINSTR_W = 16;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    HALT   = 2'd3
  } state_t;

  // Instruction classes held in opcode[5:4]
  localparam logic [CLS_W-1:0] CLS_ALU   = 2'b00;
  localparam logic [CLS_W-1:0] CLS_LI    = 2'b01;
  localparam logic [CLS_W-1:0] CLS_SALTO = 2'b10;
  localparam logic [CLS_W-1:0] CLS_ESP   = 2'b11;

  // Jump subcodes held in opcode[3:0] of the SALTO class
  localparam logic [SUB_W-1:0] SUB_J   = 4'b0000;
  localparam logic [SUB_W-1:0] SUB_JZ  = 4'b0001;
  localparam logic [SUB_W-1:0] SUB_JNZ = 4'b0010;
  localparam logic [SUB_W-1:0] SUB_JR  = 4'b0011;

  localparam logic [OPC_W-1:0] OPC_HALT    = 6'b111111;
  localparam logic [OP_W-1:0]  ALU_OP_PASS = 3'b000;

  typedef struct packed {
    logic            ir_we;
    logic            pc_we;
    logic            s_inc;
    logic            s_inc2;
    logic            s_inm;
    logic            we3;
    logic [OP_W-1:0] op;
    logic            fin;
  } ctrl_t;

  function automatic logic [CLS_W-1:0] opc_class(input logic [OPC_W-1:0] opc);
    return opc[OPC_W-1:OPC_W-CLS_W];
  endfunction

endpackage

// File: rtl/uc_multiciclo_if.sv
// Control-unit <-> datapath bundle; master is the control unit side.
// ninstr exists only when UC_CONTADOR_EN is defined.
interface uc_multiciclo_if;
  import uc_pkg::*;

  logic [OPC_W-1:0]    opcode;
  logic                z;
  logic                ir_we;
  logic                pc_we;
  logic                s_inc;
  logic                s_inc2;
  logic                s_inm;
  logic                we3;
  logic [OP_W-1:0]     op;
  logic                fin;
`ifdef UC_CONTADOR_EN
  logic [NINSTR_W-1:0] ninstr;
`endif

  modport master (
    input  opcode, z,
    output ir_we, pc_we, s_inc, s_inc2, s_inm, we3, op, fin
`ifdef UC_CONTADOR_EN
    , output ninstr
`endif
  );

  modport slave (
    output opcode, z,
    input  ir_we, pc_we, s_inc, s_inc2, s_inm, we3, op, fin
`ifdef UC_CONTADOR_EN
    , input ninstr
`endif
  );

endinterface

// File: rtl/uc_decod.sv
// EXEC-cycle control decode from the latched opcode and the datapath zero flag.
module uc_decod
  import uc_pkg::*;
(
  input  logic [OPC_W-1:0] opc_q,
  input  logic             z,
  output ctrl_t            ctrl_c
);

  logic [SUB_W-1:0] sub;
  assign sub = opc_q[SUB_W-1:0];

  always_comb begin
    ctrl_c       = '0;
    ctrl_c.pc_we = 1'b1;
    ctrl_c.s_inc = 1'b1;
    case (opc_class(opc_q))
      CLS_ALU: begin
        ctrl_c.op  = opc_q[OP_W:1];
        ctrl_c.we3 = 1'b1;
      end
      CLS_LI: begin
        ctrl_c.op    = ALU_OP_PASS;
        ctrl_c.s_inm = 1'b1;
        ctrl_c.we3   = 1'b1;
      end
      CLS_SALTO: begin
        case (sub)
          SUB_J:   ctrl_c.s_inc  = 1'b0;
          SUB_JZ:  ctrl_c.s_inc  = ~z;
          SUB_JNZ: ctrl_c.s_inc  = z;
          SUB_JR:  ctrl_c.s_inc2 = 1'b1;
          default: ctrl_c.s_inc  = 1'b1;
        endcase
      end
      default: begin
        // Halt opcode leaves PC and register file untouched
        if (opc_q == OPC_HALT) begin
          ctrl_c.pc_we = 1'b0;
          ctrl_c.s_inc = 1'b0;
        end
      end
    endcase
  end

endmodule

// File: rtl/uc_multiciclo.sv
// Multicycle control unit: FETCH -> DECODE -> EXEC per instruction, HALT on opcode 111111.
// Define UC_CONTADOR_EN to add the 16-bit executed-cycle counter ninstr.
module uc_multiciclo
  import uc_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  uc_multiciclo_if.master bus
);

  state_t           state_q, state_d;
  logic [OPC_W-1:0] opc_q;
  ctrl_t            exec_c;
  ctrl_t            ctrl_c;

  uc_decod u_decod (
    .opc_q  (opc_q),
    .z      (bus.z),
    .ctrl_c (exec_c)
  );

  // State and latched opcode; opcode is only captured in DECODE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) opc_q <= bus.opcode;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE:  state_d = EXEC;
      EXEC:    state_d = (opc_q == OPC_HALT) ? HALT : FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Output decode; EXEC is Mealy on z through the decoder
  always_comb begin
    ctrl_c = '0;
    case (state_q)
      FETCH: begin
        ctrl_c.ir_we = 1'b1;
        ctrl_c.s_inc = 1'b1;
      end
      DECODE:  ctrl_c.s_inc = 1'b1;
      EXEC:    ctrl_c       = exec_c;
      HALT:    ctrl_c.fin   = 1'b1;
      default: ctrl_c       = '0;
    endcase
  end

  assign bus.ir_we  = ctrl_c.ir_we;
  assign bus.pc_we  = ctrl_c.pc_we;
  assign bus.s_inc  = ctrl_c.s_inc;
  assign bus.s_inc2 = ctrl_c.s_inc2;
  assign bus.s_inm  = ctrl_c.s_inm;
  assign bus.we3    = ctrl_c.we3;
  assign bus.op     = ctrl_c.op;
  assign bus.fin    = ctrl_c.fin;

`ifdef UC_CONTADOR_EN
  logic [NINSTR_W-1:0] ninstr_q;

  // Counts every EXEC-or-HALT cycle, wrapping naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ninstr_q <= '0;
    end else if (state_q == EXEC || state_q == HALT) begin
      ninstr_q <= ninstr_q + NINSTR_W'(1);
    end
  end

  assign bus.ninstr = ninstr_q;
`endif

endmodule
